// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared control-flow types and constants for EX branch resolution
package mips_pkg;

  // Control-instruction class presented by decode; 3..7 are not control-flow.
  typedef enum logic [2:0] {
    BR_COND = 3'd0,
    BR_J    = 3'd1,
    BR_JR   = 3'd2
  } br_type_t;

  // Resolve FSM: idle, waiting for the delay slot to be fetched, offering the redirect.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SLOT = 2'd1,
    ST_REDIRECT  = 2'd2
  } br_state_t;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/branch_resolve_if.sv
// rtl/branch_resolve_if.sv - redirect handshake between branch resolution and fetch
interface branch_resolve_if;

  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        flush_if;

  modport master (
    output redirect_valid,
    output redirect_pc,
    output flush_if,
    input  redirect_ready
  );

  modport slave (
    input  redirect_valid,
    input  redirect_pc,
    input  flush_if,
    output redirect_ready
  );

endinterface

// File: rtl/br_target_calc.sv
// rtl/br_target_calc.sv - combinational branch/jump target selection
module br_target_calc
  import mips_pkg::*;
(
  input  logic [2:0]  br_type,
  input  logic [31:0] pc,
  input  logic [25:0] target,
  input  logic [31:0] rs,
  output logic [31:0] tgt
);

  logic [31:0] pc4;
  logic [31:0] cond_off;

  assign pc4      = pc + PC_INC;
  assign cond_off = {{14{target[15]}}, target[15:0], 2'b00};

  // Pick the target for the instruction class; JR passes rs through unaligned.
  always_comb begin
    tgt = rs;
    case (br_type)
      BR_COND: tgt = pc4 + cond_off;
      BR_J:    tgt = {pc4[31:28], target, 2'b00};
      default: tgt = rs;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - EX branch resolution with delay-slot wait and fetch redirect
module branch_resolve
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [2:0]       ex_br_type,
  input  logic [31:0]      ex_pc,
  input  logic [25:0]      ex_target,
  input  logic [31:0]      ex_rs,
  input  logic             alu_z,
  input  logic             ds_fetched,
  output logic             ex_stall,
  branch_resolve_if.master rd,
  output logic [31:0]      br_cnt,
  output logic [31:0]      taken_cnt
);

  br_state_t   state_q, state_d;
  logic [31:0] tgt;
  logic [31:0] redirect_pc_q;
  logic [31:0] br_cnt_q;
  logic [31:0] taken_cnt_q;
  logic        accept;
  logic        taken;

  br_target_calc u_calc (
    .br_type (ex_br_type),
    .pc      (ex_pc),
    .target  (ex_target),
    .rs      (ex_rs),
    .tgt     (tgt)
  );

  assign accept = ex_valid && (ex_br_type <= 3'd2) && (state_q == ST_IDLE);
  // alu_z low means the compare condition held.
  assign taken  = (ex_br_type == BR_COND) ? !alu_z : 1'b1;

  assign ex_stall          = (state_q != ST_IDLE);
  assign rd.redirect_valid = (state_q == ST_REDIRECT);
  assign rd.redirect_pc    = redirect_pc_q;
  assign rd.flush_if       = rd.redirect_valid && rd.redirect_ready;
  assign br_cnt            = br_cnt_q;
  assign taken_cnt         = taken_cnt_q;

  // State register; reset abandons any pending redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: a taken branch waits for its delay slot before redirecting fetch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (accept && taken) state_d = ds_fetched ? ST_REDIRECT : ST_WAIT_SLOT;
      ST_WAIT_SLOT: if (ds_fetched) state_d = ST_REDIRECT;
      ST_REDIRECT:  if (rd.redirect_ready) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Target captured only on a taken accept so it holds steady while offered.
  always_ff @(posedge clk) begin
    if (!rst_n)              redirect_pc_q <= RESET_PC;
    else if (accept && taken) redirect_pc_q <= tgt;
  end

  // Wrapping performance counters: accepted control instructions and completed redirects.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cnt_q    <= 32'd0;
      taken_cnt_q <= 32'd0;
    end else begin
      if (accept)      br_cnt_q    <= br_cnt_q + 32'd1;
      if (rd.flush_if) taken_cnt_q <= taken_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed self-checking bench for branch_resolve
module tb_branch_resolve;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [2:0]  ex_br_type;
  logic [31:0] ex_pc;
  logic [25:0] ex_target;
  logic [31:0] ex_rs;
  logic        alu_z;
  logic        ds_fetched;
  logic        ex_stall;
  logic [31:0] br_cnt;
  logic [31:0] taken_cnt;

  branch_resolve_if rd_if ();

  branch_resolve #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_br_type (ex_br_type),
    .ex_pc      (ex_pc),
    .ex_target  (ex_target),
    .ex_rs      (ex_rs),
    .alu_z      (alu_z),
    .ds_fetched (ds_fetched),
    .ex_stall   (ex_stall),
    .rd         (rd_if),
    .br_cnt     (br_cnt),
    .taken_cnt  (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a redirect is outstanding or not; it can be offered once the slot is in.
  bit          m_busy, m_slot;
  logic [31:0] m_pc;
  logic [31:0] m_br, m_tk;
  bit          chk_en  = 1'b1;
  bit          preload = 1'b0;

  function automatic logic [31:0] exp_target(input logic [2:0] t, input logic [31:0] pc,
                                             input logic [25:0] tg, input logic [31:0] rs);
    int          off;
    logic [31:0] r;
    off = int'($signed(tg[15:0]));
    r   = rs;
    if (t == 3'd0)      r = pc + 32'd4 + 32'(off * 4);
    else if (t == 3'd1) r = ((pc + 32'd4) & 32'hF000_0000) | (32'(tg) * 32'd4);
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_slot = 0; m_pc = RST_PC; m_br = 0; m_tk = 0;
    end else if (preload) begin
      m_br = 32'hFFFF_FFFF; m_tk = 32'hFFFF_FFFF;
    end else if (m_busy) begin
      if (m_slot && rd_if.redirect_ready) begin
        m_busy = 0; m_tk = m_tk + 1;
      end else if (ds_fetched) m_slot = 1;
    end else if (ex_valid && ex_br_type <= 3'd2) begin
      m_br = m_br + 1;
      if (ex_br_type != 3'd0 || !alu_z) begin
        m_busy = 1;
        m_slot = ds_fetched;
        m_pc   = exp_target(ex_br_type, ex_pc, ex_target, ex_rs);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_stall", 32'(ex_stall), 32'(m_busy));
      chk("m_rvalid", 32'(rd_if.redirect_valid), 32'(m_busy && m_slot));
      chk("m_flush", 32'(rd_if.flush_if), 32'(m_busy && m_slot && rd_if.redirect_ready));
      chk("m_rpc", rd_if.redirect_pc, m_pc);
      chk("m_br_cnt", br_cnt, m_br);
      chk("m_taken_cnt", taken_cnt, m_tk);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    ex_valid = 0; ex_br_type = 3'd3; ex_pc = 0; ex_target = 0; ex_rs = 0;
    alu_z = 1; ds_fetched = 0; rd_if.redirect_ready = 0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  task automatic present(input logic [2:0] t, input logic [31:0] pc, input logic [25:0] tg,
                         input logic [31:0] rs, input logic z, input logic ds, input logic rr);
    ex_valid = 1; ex_br_type = t; ex_pc = pc; ex_target = tg; ex_rs = rs;
    alu_z = z; ds_fetched = ds; rd_if.redirect_ready = rr;
  endtask

  initial begin
    rst_n = 0;
    idle_in();
    #2;
    // Reset held 3 cycles with random inputs.
    for (int i = 0; i < 3; i++) begin
      ex_valid = 1'($urandom); ex_br_type = 3'($urandom); ex_pc = $urandom;
      ex_target = 26'($urandom); ex_rs = $urandom; alu_z = 1'($urandom);
      ds_fetched = 1'($urandom); rd_if.redirect_ready = 1'($urandom);
      step();
    end
    @(negedge clk);
    chk("rst_rvalid", 32'(rd_if.redirect_valid), 32'd0);
    chk("rst_rpc", rd_if.redirect_pc, 32'hBFC0_0000);
    chk("rst_flush", 32'(rd_if.flush_if), 32'd0);
    chk("rst_stall", 32'(ex_stall), 32'd0);
    chk("rst_br_cnt", br_cnt, 32'd0);
    chk("rst_taken_cnt", taken_cnt, 32'd0);
    do_reset();

    // COND taken, backward offset.
    present(3'd0, 32'h0040_0010, 26'h000FFFC, 32'h0, 1'b0, 1'b1, 1'b1);
    step();
    ex_valid = 0;
    @(negedge clk);
    chk("cond_rvalid", 32'(rd_if.redirect_valid), 32'd1);
    chk("cond_rpc", rd_if.redirect_pc, 32'h0040_0004);
    chk("cond_flush", 32'(rd_if.flush_if), 32'd1);
    step();
    @(negedge clk);
    chk("cond_br_cnt", br_cnt, 32'd1);
    chk("cond_taken_cnt", taken_cnt, 32'd1);
    chk("cond_idle", 32'(ex_stall), 32'd0);

    // COND not taken back-to-back.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      present(3'd0, 32'h0000_1000 + 32'(i * 4), 26'h0000010, 32'h0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      chk("nt_stall", 32'(ex_stall), 32'd0);
      chk("nt_rvalid", 32'(rd_if.redirect_valid), 32'd0);
      step();
    end
    ex_valid = 0;
    @(negedge clk);
    chk("nt_br_cnt", br_cnt, 32'd4);
    chk("nt_taken_cnt", taken_cnt, 32'd0);

    // J with late delay slot, backpressure, and a competing branch.
    do_reset();
    present(3'd1, 32'h8000_0000, 26'h0000100, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step();
      ex_valid = (k == 2);
      if (k == 2) begin ex_br_type = 3'd0; alu_z = 0; end
      if (k == 3) ds_fetched = 1;
      if (k == 6) rd_if.redirect_ready = 1;
      @(negedge clk);
      chk("j_stall", 32'(ex_stall), 32'd1);
      chk("j_rvalid", 32'(rd_if.redirect_valid), (k >= 4) ? 32'd1 : 32'd0);
      if (k >= 4) chk("j_rpc", rd_if.redirect_pc, 32'h8000_0400);
    end
    step();
    idle_in();
    @(negedge clk);
    chk("j_br_cnt", br_cnt, 32'd1);
    chk("j_taken_cnt", taken_cnt, 32'd1);
    chk("j_idle", 32'(ex_stall), 32'd0);

    // JR with counters preloaded to wrap.
    do_reset();
    chk_en = 0;
    preload = 1;
    force dut.br_cnt_q = 32'hFFFF_FFFF;
    force dut.taken_cnt_q = 32'hFFFF_FFFF;
    step();
    release dut.br_cnt_q;
    release dut.taken_cnt_q;
    preload = 0;
    chk_en = 1;
    present(3'd2, 32'h0000_2000, 26'h0, 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b1);
    step();
    ex_valid = 0;
    @(negedge clk);
    chk("jr_rpc", rd_if.redirect_pc, 32'hFFFF_FFF0);
    chk("jr_br_wrap", br_cnt, 32'd0);
    step();
    @(negedge clk);
    chk("jr_taken_wrap", taken_cnt, 32'd0);

    // Reset while offering a redirect.
    do_reset();
    present(3'd1, 32'h0000_3000, 26'h0000040, 32'h0, 1'b1, 1'b1, 1'b0);
    step();
    ex_valid = 0;
    @(negedge clk);
    chk("mr_rvalid_pre", 32'(rd_if.redirect_valid), 32'd1);
    rst_n = 0;
    step();
    rst_n = 1;
    rd_if.redirect_ready = 1;
    @(negedge clk);
    chk("mr_rvalid", 32'(rd_if.redirect_valid), 32'd0);
    chk("mr_stall", 32'(ex_stall), 32'd0);
    chk("mr_flush", 32'(rd_if.flush_if), 32'd0);
    chk("mr_br_cnt", br_cnt, 32'd0);
    chk("mr_taken_cnt", taken_cnt, 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Resolves control-flow instructions in EX, downstream of the ALU compare sub-units (EQ/NEQ/LEZ/GTZ/LTZ/GEZ). Consumes the ALU zero flag for conditional branches, computes the branch/jump target, honours the single MIPS delay slot, and hands a PC redirect to fetch over a valid/ready handshake. Also keeps wrapping branch and taken-branch performance counters.

## Interface
- `RESET_PC`, default 32'h0000_0000: value of `redirect_pc` while in reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `ex_valid`  in  1  EX holds a valid instruction this cycle.
- `ex_br_type`  in  3  0=COND, 1=J, 2=JR, 3..7=not a control instruction.
- `ex_pc`  in  32  PC of the instruction in EX.
- `ex_target`  in  26  J: instr[25:0]; COND: low 16 bits are the offset.
- `ex_rs`  in  32  forwarded rs value (JR target).
- `alu_z`  in  1  ALU compare zero flag. 0 = condition true (S!=0), 1 = false.
- `ds_fetched`  in  1  the delay-slot instruction (`ex_pc+4`) has been fetched; level, held by fetch until a redirect completes.
- `ex_stall`  out  1  EX must hold; no new instruction accepted.
- `redirect_valid`  out  1  redirect request to fetch.
- `redirect_pc`  out  32  redirect target; stable while `redirect_valid`.
- `redirect_ready`  in  1  fetch accepts the redirect.
- `flush_if`  out  1  one-cycle pulse: squash the instruction in IF (beyond the delay slot).
- `br_cnt`  out  32  control instructions accepted.
- `taken_cnt`  out  32  redirects accepted by fetch.

## Operation
- Accept: `ex_valid && ex_br_type<=2 && state==IDLE`. Types 3..7 and `ex_valid=0` are ignored.
- Taken: COND when `alu_z==0`; J and JR always.
- Target, computed at accept and registered, all modulo 2^32:
  - COND: `ex_pc + 4 + (sext(ex_target[15:0]) << 2)`.
  - J: `{(ex_pc+4)[31:28], ex_target, 2'b00}`.
  - JR: `ex_rs`, used as-is with no alignment check.
- FSM states: IDLE, WAIT_SLOT, REDIRECT.
  - IDLE, accept, not taken: stay IDLE; `br_cnt` +1.
  - IDLE, accept, taken, `ds_fetched=1`: go to REDIRECT; `br_cnt` +1.
  - IDLE, accept, taken, `ds_fetched=0`: go to WAIT_SLOT; `br_cnt` +1.
  - WAIT_SLOT: go to REDIRECT when `ds_fetched=1`, else hold.
  - REDIRECT: `redirect_valid=1`. When `redirect_ready=1`, the handshake fires: `flush_if=1` that cycle, `taken_cnt` +1, next state IDLE.
- `ex_stall = (state != IDLE)`, combinational from state.
- Counters wrap from 2^32-1 to 0.

## Timing
- Reset values:
  - state=IDLE.
  - `redirect_valid=0`, `redirect_pc=RESET_PC`.
  - `flush_if=0`, `ex_stall=0`.
  - `br_cnt=0`, `taken_cnt=0`.
- Reset asserted mid-operation (WAIT_SLOT or REDIRECT): abandons the pending redirect at that edge; no handshake and no count.
- Latency, taken branch with `ds_fetched=1` at accept edge T:
  - `redirect_valid` high from T+1.
  - Earliest handshake at T+1.
  - A new accept is possible at T+2.
- Not-taken branch: zero stall cycles; back-to-back accepts every cycle.
- Once `redirect_valid` is high, it and `redirect_pc` stay stable until the handshake. `redirect_ready` while `redirect_valid=0` has no effect.
- `ds_fetched` is sampled at the accept edge and in WAIT_SLOT only.
- `flush_if` is combinational: `redirect_valid && redirect_ready`.
- `alu_z` is only used for COND, at the accept edge.

## Structure
- Shared package `mips_pkg`:
  - `br_type_t` enum (BR_COND=0, BR_J=1, BR_JR=2).
  - FSM state encoding (2 bits).
  - Constant `PC_INC=4`.
- Single natural sub-module `br_target_calc`: combinational target adder/concatenation selected by `ex_br_type`. FSM and counters live in `branch_resolve`.

## Test plan
- Reset: hold `rst_n=0` 3 cycles with random inputs.
  - All outputs at reset values; `redirect_pc=RESET_PC`.
- COND taken, backward offset: `ex_pc=0x0040_0010`, `ex_target[15:0]=0xFFFC`, `alu_z=0`, `ds_fetched=1`, `redirect_ready=1`.
  - `redirect_pc=0x0040_0004` at T+1; `flush_if` pulse at T+1.
  - `br_cnt=1`, `taken_cnt=1`.
- COND not taken: `alu_z=1` on 4 consecutive cycles.
  - `ex_stall=0` throughout; `redirect_valid=0`.
  - `br_cnt=4`, `taken_cnt=0`.
- J with late delay slot and backpressure: `ex_pc=0x8000_0000`, `ex_target=0x0000_100`, `ds_fetched` rises at T+3, `redirect_ready` rises at T+6.
  - `redirect_pc=0x8000_0400`; `redirect_valid` from T+4 to T+6, stable.
  - `ex_stall` high T+1..T+6; a second branch presented meanwhile is not counted.
- JR plus wrap: `ex_rs=0xFFFF_FFF0`, counters preloaded to 0xFFFF_FFFF via force.
  - `redirect_pc=0xFFFF_FFF0`; both counters read 0 after the handshake.
- Reset mid-REDIRECT: `rst_n=0` for one edge while `redirect_valid=1`, `redirect_ready=0`.
  - Next cycle: IDLE, `redirect_valid=0`, no `flush_if` pulse, counters 0.
